qcv_load_store_unit: RTL
========================

// Module: qcv_load_store_unit
// PURPOSE
//  Executes one load/store at a time on the core data bus (req/gnt/rvalid
//  protocol). Aligns and extends load data, then drives the register-file
//  write port (rd) for loads. Sits between execute and the FF register file;
//  the write port is single-cycle and write-only.
// PARAMETERS
//  ERR_WB_ZERO  0  1: a load bus error also writes 32'h0 to rd; 0: no rd write
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_ni         in   1   reset, asynchronous, active-low
//  lsu_req_i      in   1   request valid; accepted when lsu_ready_o=1
//  lsu_we_i       in   1   1=store, 0=load
//  lsu_type_i     in   2   00=byte, 01=half, 10=word (11 treated as word)
//  lsu_sign_ext_i in   1   loads: 1=sign-extend, 0=zero-extend
//  lsu_addr_i     in   32  byte address
//  lsu_wdata_i    in   32  store data, LSB-aligned
//  lsu_rd_i       in   5   load destination register
//  lsu_ready_o    out  1   high only in IDLE
//  data_req_o     out  1   bus request; held until data_gnt_i
//  data_gnt_i     in   1   bus grant
//  data_rvalid_i  in   1   response valid (>=1 cycle after gnt)
//  data_err_i     in   1   response error, qualified by data_rvalid_i
//  data_addr_o    out  32  word-aligned address
//  data_we_o      out  1   write enable
//  data_be_o      out  4   byte enables
//  data_wdata_o   out  32  lane-shifted store data
//  data_rdata_i   in   32  load data
//  rf_waddr_o     out  5   register-file write address
//  rf_wdata_o     out  32  register-file write data
//  rf_we_o        out  1   register-file write enable, 1-cycle pulse
//  load_err_o     out  1   1-cycle pulse: load bus error
//  store_err_o    out  1   1-cycle pulse: store bus error
//  misaligned_o   out  1   1-cycle pulse: misaligned access rejected
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except lsu_ready_o=1. Reset mid-access
//    drops data_req_o immediately; responses for the old access are ignored.
//  - FSM: IDLE -> WAIT_GNT on accept (lsu_req_i & lsu_ready_o; inputs latched).
//    WAIT_GNT -> WAIT_RVALID on data_gnt_i; WAIT_RVALID -> IDLE on data_rvalid_i.
//  - data_req_o = (state==WAIT_GNT); addr/we/be/wdata stable while req high.
//  - Requests while not ready are ignored; rvalid outside WAIT_RVALID ignored.
//  - Offset k=addr[1:0]: be byte=4'b0001<<k, half=4'b0011<<k, word=4'b1111;
//    data_wdata_o = wdata<<(8k); data_addr_o = {addr[31:2],2'b00}.
//  - Load data: (rdata>>8k), take low 8/16/32 bits, extend per sign_ext.
//  - Writeback: cycle after load rvalid (no err): rf_we_o=1, rf_waddr_o=rd,
//    rf_wdata_o=aligned data; rd=0 suppresses rf_we_o. Stores never write rf.
//  - Timing, 0-wait bus: accept c0, req c1 (gnt c1), rvalid c2, rf_we_o and
//    lsu_ready_o c3. Back-to-back accept possible at c3.
//  - Error: rvalid&err -> load_err_o/store_err_o pulse next cycle; rf write
//    only if ERR_WB_ZERO=1 (wdata 0, rd!=0).
//  - Misaligned = half with k[0]=1, or word with k!=0; byte never misaligned.
// CONFIGURATION
//  QCV_LSU_MISALIGNED_EN undefined: misaligned access issues no bus request;
//    misaligned_o pulses cycle after accept; state returns to IDLE.
//  QCV_LSU_MISALIGNED_EN defined: split into two word accesses (extra states
//    WAIT_GNT2/WAIT_RVALID2): addr A&~3 with be=(be_full<<k)[3:0], then
//    (A&~3)+4 with be=(be_full<<k)[7:4]; wdata lanes <<8k / >>8(4-k).
//    Load data = ({rdata2,rdata1}>>8k) then extend. Error on phase 1 aborts
//    phase 2; error on either phase reported once. misaligned_o never asserted.
// TESTING
//  1. LW x5, addr 0x100, rdata 0xDEADBEEF, 0-wait -> rf_we_o c3, waddr 5, wdata 0xDEADBEEF
//  2. LB signed, addr 0x103, rdata 0x80112233 -> wdata 0xFFFFFF80; LBU -> 0x00000080
//  3. SH addr 0x102, wdata 0x0000ABCD -> be 4'b1100, data_wdata 0xABCD0000, no rf_we_o
//  4. gnt withheld 3 cycles then rvalid+err on load -> req stable 4 cycles, load_err_o pulse, no rf write
//  5. LW addr 0x101 -> macro off: misaligned_o pulse, no req; macro on: be 1110 then 0001,
//     rdata1 0x44332211, rdata2 0x88776655 -> wdata 0x55443322
//  6. rst_ni low while in WAIT_RVALID -> data_req_o/rf_we_o 0, lsu_ready_o 1, late rvalid ignored

Source files
------------

// File: rtl/qcv_load_store_unit_if.sv
// Core data bus (req/gnt/rvalid) between the load/store unit and memory.
// The unit drives the request side through the master modport.
interface qcv_load_store_unit_if;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_err_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );
endinterface

// File: rtl/qcv_load_store_unit.sv
// Single-outstanding load/store unit: lane alignment, load extension and rd writeback.
// Define QCV_LSU_MISALIGNED_EN to split misaligned accesses into two word accesses.
module qcv_load_store_unit #(
    parameter bit ERR_WB_ZERO = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [4:0]  lsu_rd_i,
    output logic        lsu_ready_o,
    qcv_load_store_unit_if.master bus,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        rf_we_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic        misaligned_o
);
    // state        | meaning
    // IDLE         | ready for a new access
    // WAIT_GNT     | request held on bus (first/only word)
    // WAIT_RVALID  | granted, awaiting response
    // WAIT_GNT2/.. | second word of a split misaligned access
    typedef enum logic [2:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_GNT2, WAIT_RVALID2} state_t;

    state_t      state, state_nxt;
    logic        we_q, sext_q;
    logic [1:0]  type_q;
    logic [31:0] addr_q, wdata_q;
    logic [4:0]  rd_q;
    logic        rf_we_q, load_err_q, store_err_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;
    logic        accept, mis_in, done;
    logic [1:0]  k;
    logic [3:0]  be_full;
    logic [31:0] load_data;
`ifdef QCV_LSU_MISALIGNED_EN
    logic        split_q;
    logic [31:0] rdata1_q;
    logic [7:0]  be8;
    logic [63:0] wdata64, rdata64;
    logic        phase2;
`else
    logic        misaligned_q;
`endif

    function automatic logic [31:0] extend(input logic [31:0] s, input logic [1:0] t,
                                           input logic se);
        case (t)
            2'b00:   return se ? {{24{s[7]}}, s[7:0]} : {24'b0, s[7:0]};
            2'b01:   return se ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign k      = addr_q[1:0];
    assign accept = lsu_req_i & (state == IDLE);
    assign mis_in = ((lsu_type_i == 2'b01) & lsu_addr_i[0]) | (lsu_type_i[1] & (|lsu_addr_i[1:0]));

    always_comb begin
        case (type_q)
            2'b00:   be_full = 4'b0001;
            2'b01:   be_full = 4'b0011;
            default: be_full = 4'b1111;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
`ifdef QCV_LSU_MISALIGNED_EN
                if (accept) state_nxt = WAIT_GNT;
`else
                if (accept && !mis_in) state_nxt = WAIT_GNT;
`endif
            end
            WAIT_GNT:    if (bus.data_gnt_i) state_nxt = WAIT_RVALID;
            WAIT_RVALID: begin
`ifdef QCV_LSU_MISALIGNED_EN
                if (bus.data_rvalid_i)
                    state_nxt = (split_q && !bus.data_err_i) ? WAIT_GNT2 : IDLE;
`else
                if (bus.data_rvalid_i) state_nxt = IDLE;
`endif
            end
`ifdef QCV_LSU_MISALIGNED_EN
            WAIT_GNT2:    if (bus.data_gnt_i) state_nxt = WAIT_RVALID2;
            WAIT_RVALID2: if (bus.data_rvalid_i) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lsu_ready_o      = (state == IDLE);
        bus.data_req_o   = 1'b0;
        bus.data_addr_o  = '0;
        bus.data_we_o    = 1'b0;
        bus.data_be_o    = '0;
        bus.data_wdata_o = '0;
`ifdef QCV_LSU_MISALIGNED_EN
        phase2  = (state == WAIT_GNT2);
        be8     = {4'b0, be_full} << k;
        wdata64 = {32'b0, wdata_q} << {k, 3'b000};
        rdata64 = (state == WAIT_RVALID2) ? {bus.data_rdata_i, rdata1_q} : {32'b0, bus.data_rdata_i};
        done    = ((state == WAIT_RVALID) && bus.data_rvalid_i && (bus.data_err_i || !split_q))
                || ((state == WAIT_RVALID2) && bus.data_rvalid_i);
        if (state == WAIT_GNT || state == WAIT_GNT2) begin
            bus.data_req_o   = 1'b1;
            bus.data_addr_o  = {addr_q[31:2], 2'b00} + (phase2 ? 32'd4 : 32'd0);
            bus.data_we_o    = we_q;
            bus.data_be_o    = phase2 ? be8[7:4] : be8[3:0];
            bus.data_wdata_o = phase2 ? wdata64[63:32] : wdata64[31:0];
        end
        load_data = extend(32'(rdata64 >> {k, 3'b000}), type_q, sext_q);
`else
        done = (state == WAIT_RVALID) && bus.data_rvalid_i;
        if (state == WAIT_GNT) begin
            bus.data_req_o   = 1'b1;
            bus.data_addr_o  = {addr_q[31:2], 2'b00};
            bus.data_we_o    = we_q;
            bus.data_be_o    = be_full << k;
            bus.data_wdata_o = wdata_q << {k, 3'b000};
        end
        load_data = extend(bus.data_rdata_i >> {k, 3'b000}, type_q, sext_q);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q <= 1'b0; sext_q <= 1'b0; type_q <= '0;
            addr_q <= '0; wdata_q <= '0; rd_q <= '0;
            rf_we_q <= 1'b0; load_err_q <= 1'b0; store_err_q <= 1'b0;
            rf_waddr_q <= '0; rf_wdata_q <= '0;
`ifdef QCV_LSU_MISALIGNED_EN
            split_q <= 1'b0; rdata1_q <= '0;
`else
            misaligned_q <= 1'b0;
`endif
        end else begin
            rf_we_q     <= 1'b0;
            load_err_q  <= 1'b0;
            store_err_q <= 1'b0;
`ifndef QCV_LSU_MISALIGNED_EN
            misaligned_q <= 1'b0;
`endif
            if (accept) begin
                we_q    <= lsu_we_i;
                sext_q  <= lsu_sign_ext_i;
                type_q  <= lsu_type_i;
                addr_q  <= lsu_addr_i;
                wdata_q <= lsu_wdata_i;
                rd_q    <= lsu_rd_i;
`ifdef QCV_LSU_MISALIGNED_EN
                split_q <= mis_in;
`else
                misaligned_q <= mis_in;
`endif
            end
`ifdef QCV_LSU_MISALIGNED_EN
            if (state == WAIT_RVALID && bus.data_rvalid_i && !bus.data_err_i && split_q)
                rdata1_q <= bus.data_rdata_i;
`endif
            if (done) begin
                rf_waddr_q <= rd_q;
                if (bus.data_err_i) begin
                    load_err_q  <= ~we_q;
                    store_err_q <= we_q;
                    rf_we_q     <= ~we_q & ERR_WB_ZERO & (|rd_q);
                    rf_wdata_q  <= '0;
                end else begin
                    rf_we_q    <= ~we_q & (|rd_q);
                    rf_wdata_q <= load_data;
                end
            end
        end
    end

    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign load_err_o  = load_err_q;
    assign store_err_o = store_err_q;
`ifdef QCV_LSU_MISALIGNED_EN
    assign misaligned_o = 1'b0;
`else
    assign misaligned_o = misaligned_q;
`endif
endmodule
